// File: rtl/mont_modexp_ctrl_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation controller.
package mont_modexp_ctrl_pkg;

  localparam int unsigned DEF_WIDTH     = 256;
  localparam int unsigned DEF_EXP_WIDTH = 256;
  localparam int unsigned DEF_TIMEOUT   = 1024;

  // Constant 1 operand, used for domain exit and for R mod N.
  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_M,
    ST_PRE_X,
    ST_SQR,
    ST_MUL,
    ST_POST,
    ST_FIN
  } top_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_GUARD,
    HS_WAIT
  } hs_state_e;

endpackage

// File: rtl/mont_modexp_ctrl_req_seq.sv
// Per-product start/done handshake with the multiplier, with a bounded wait.
module mont_req_seq
  import mont_modexp_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic mul_done,
  output logic mul_start_n,
  output logic ack_c,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  hs_state_e        hs_q, hs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_n_q, start_n_d;

  // Next handshake state; done is ignored in ISSUE/GUARD because it may still be stale.
  always_comb begin
    hs_d      = hs_q;
    cnt_d     = cnt_q;
    start_n_d = 1'b1;
    ack_c     = 1'b0;
    timeout_c = 1'b0;
    case (hs_q)
      HS_IDLE: begin
        if (req) begin
          hs_d      = HS_ISSUE;
          start_n_d = 1'b0;
        end
      end
      HS_ISSUE: begin
        hs_d  = HS_GUARD;
        cnt_d = '0;
      end
      HS_GUARD: hs_d = HS_WAIT;
      HS_WAIT: begin
        if (mul_done) begin
          ack_c = 1'b1;
          hs_d  = HS_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          hs_d      = HS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  // Handshake state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q      <= HS_IDLE;
      cnt_q     <= '0;
      start_n_q <= 1'b1;
    end else begin
      hs_q      <= hs_d;
      cnt_q     <= cnt_d;
      start_n_q <= start_n_d;
    end
  end

  assign mul_start_n = start_n_q;

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
module mont_modexp_ctrl
  import mont_modexp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modn,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     res,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_n,
  output logic                 mul_start_n,
  input  logic                 mul_done,
  input  logic [WIDTH-1:0]     mul_out
);

  localparam int unsigned    IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

  top_state_e           st_q, st_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d;
  logic [WIDTH-1:0]     res_q, res_d, a_q, a_d, b_q, b_d, n_q, n_d;
  logic [WIDTH-1:0]     r2_q, r2_d, x_q, x_d, mbar_q, mbar_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 ack_c, timeout_c;

  mont_req_seq #(.TIMEOUT(TIMEOUT)) u_req_seq (
    .clk        (clk),
    .rst        (rst),
    .req        (req_q),
    .mul_done   (mul_done),
    .mul_start_n(mul_start_n),
    .ack_c      (ack_c),
    .timeout_c  (timeout_c)
  );

  // Top sequencing: pick the next product and its operands when the current one completes.
  always_comb begin
    st_d   = st_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    req_d  = 1'b0;
    res_d  = res_q;
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    r2_d   = r2_q;
    x_d    = x_q;
    mbar_d = mbar_q;
    exp_d  = exp_q;
    idx_d  = idx_q;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          exp_d  = exp;
          r2_d   = r2;
          n_d    = modn;
          a_d    = msg;
          b_d    = r2;
          idx_d  = IDX_W'(EXP_WIDTH - 1);
          busy_d = 1'b1;
          req_d  = 1'b1;
          st_d   = ST_PRE_M;
        end
      end
      ST_FIN: begin
        res_d  = x_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = ST_IDLE;
      end
      default: begin
        if (timeout_c) begin
          res_d  = '0;
          err_d  = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
          st_d   = ST_IDLE;
        end else if (ack_c) begin
          // Most transitions square the fresh result; exceptions override below.
          x_d   = mul_out;
          a_d   = mul_out;
          b_d   = mul_out;
          req_d = 1'b1;
          case (st_q)
            ST_PRE_M: begin
              mbar_d = mul_out;
              x_d    = x_q;
              a_d    = r2_q;
              b_d    = ONE_W;
              st_d   = ST_PRE_X;
            end
            ST_PRE_X: st_d = ST_SQR;
            ST_SQR: begin
              if (exp_q[idx_q]) begin
                b_d  = mbar_q;
                st_d = ST_MUL;
              end else if (idx_q == '0) begin
                b_d  = ONE_W;
                st_d = ST_POST;
              end else begin
                idx_d = idx_q - IDX_W'(1);
              end
            end
            ST_MUL: begin
              if (idx_q == '0) begin
                b_d  = ONE_W;
                st_d = ST_POST;
              end else begin
                idx_d = idx_q - IDX_W'(1);
                st_d  = ST_SQR;
              end
            end
            ST_POST: begin
              a_d   = a_q;
              b_d   = b_q;
              req_d = 1'b0;
              st_d  = ST_FIN;
            end
            default: st_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      req_q  <= 1'b0;
      res_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r2_q   <= '0;
      x_q    <= '0;
      mbar_q <= '0;
      exp_q  <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      req_q  <= req_d;
      res_q  <= res_d;
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      r2_q   <= r2_d;
      x_q    <= x_d;
      mbar_q <= mbar_d;
      exp_q  <= exp_d;
      idx_q  <= idx_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign res   = res_q;
  assign mul_a = a_q;
  assign mul_b = b_q;
  assign mul_n = n_q;

endmodule

// File: doc/mont_modexp_ctrl.md
Name: mont_modexp_ctrl

Overview:
- Initiator-side controller for the 256-bit radix-2 Montgomery multiplier (start/done responder).
- Computes RES = M^E mod N by issuing a sequence of Montgomery products to the multiplier:
  - domain entry,
  - left-to-right square-and-multiply,
  - domain exit.
- Sits between the host/RSA top and one multiplier instance; owns every multiplier operand and handshake.

Parameters:
- WIDTH, 256, operand/modulus width; must match the multiplier.
- EXP_WIDTH, 256, exponent width; all bits scanned MSB first.
- TIMEOUT, 1024, max cycles to wait for mul_done per product before flagging an error.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- msg  in  WIDTH  base M (M < N).
- exp  in  EXP_WIDTH  exponent E.
- modn  in  WIDTH  modulus N (odd, > 1).
- r2  in  WIDTH  precomputed 2^(2*WIDTH) mod N.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when res is valid.
- err  out  1  one-cycle pulse with done on multiplier timeout.
- res  out  WIDTH  result; held until next accepted start.
- mul_a  out  WIDTH  multiplier operand A.
- mul_b  out  WIDTH  multiplier operand B.
- mul_n  out  WIDTH  multiplier modulus (registered copy of modn).
- mul_start_n  out  1  active-low start pulse to multiplier.
- mul_done  in  1  multiplier completion level.
- mul_out  in  WIDTH  multiplier result.

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, res=0.
  - mul_a=0, mul_b=0, mul_n=0, mul_start_n=1.
  - FSM=IDLE.
  - Reset mid-operation aborts immediately with the same values. The multiplier is left unrestarted; the next product issues a fresh pulse.
- Start handling:
  - start in IDLE latches msg, exp, modn, r2 into internal registers and sets busy next cycle.
  - start while busy is ignored; latched values are unchanged.
- Top FSM states:
  - IDLE: wait for start.
  - PRE_M: Mbar = mont(msg, r2).
  - PRE_X: X = mont(r2, 1), i.e. R mod N.
  - SQR: X = mont(X, X).
  - MUL: X = mont(X, Mbar); entered only if exp[idx]==1.
  - POST: X = mont(X, 1).
  - FIN: res <= X; done=1 for one cycle; busy=0 the same cycle; return to IDLE.
- Transitions and exponent index:
  - idx starts at EXP_WIDTH-1.
  - After SQR: go to MUL if exp[idx]==1, else decrement idx.
  - After MUL: decrement idx.
  - When idx reaches 0 and its SQR/MUL is complete, go to POST.
  - Every exponent bit is scanned; there is no leading-zero skip, so latency is data-independent except for popcount.
  - Product count = 2 + EXP_WIDTH + popcount(E) + 1.
- Per-product handshake (sub-FSM):
  - ISSUE: operands stable on mul_a/mul_b; mul_start_n=0 for exactly one cycle.
  - GUARD: one cycle; mul_done ignored, since the multiplier clears done asynchronously on start.
  - WAIT: first cycle with mul_done==1 captures mul_out into the destination register; return ACK to top FSM.
  - Operands are held constant from ISSUE through ACK.
- Timeout:
  - The wait counter resets on ISSUE.
  - If it reaches TIMEOUT with no mul_done: abort, res=0, err=1 and done=1 in the same cycle, return to IDLE.
- Width rules:
  - All intermediates are WIDTH bits.
  - The constant 1 operand is {WIDTH-1 zeros, 1}.
  - Inputs violating M<N, N odd, or r2 correct give an undefined res but the sequence still terminates.
- E=0: the sequence still runs all squares; res=1.

Decomposition:
- Shared package:
  - top-FSM state enum;
  - handshake sub-state enum;
  - ONE constant (WIDTH-bit 1);
  - default WIDTH/EXP_WIDTH/TIMEOUT values.
- Sub-module mont_req_seq:
  - issue/guard/wait/timeout handshake with the multiplier;
  - interface req in, ack/timeout out.
  - Instantiated once; the top holds X, Mbar, idx and the state.

Test Plan:
- Normal: N=13, M=5, E=3, r2=9; multiplier behavioural model with 258-cycle latency -> res=8, done one pulse, err=0, exactly 261 mul_start_n pulses.
- E=0, M=7, N=13, r2=9 -> res=1; 259 products issued.
- E=1, M=7, N=13, r2=9 -> res=7; one MUL state, only at idx=0.
- Timeout: model never asserts mul_done, TIMEOUT=1024 -> err=1 and done=1 in the same cycle, res=0, busy falls, 1024+ISSUE+GUARD cycles after the first pulse.
- start pulsed again mid-run with different msg -> ignored; result matches the first request.
- rst asserted during SQR -> next cycle all outputs at reset values, mul_start_n=1; a subsequent normal run still yields res=8.
